// File: rtl/maxnet_controller.sv
// MaxNet winner-take-all sequencer: loads inputs, drives the per-round
// activation/multiply/add strobes and captures the surviving value.
module maxnet_controller #(
    parameter int MULT_CYCLES = 1,
    parameter int MAX_ITER    = 64,
    parameter int ITER_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       eps_in,
    input  logic              found,
    input  logic [31:0]       max_in,
    output logic              main_write,
    output logic              actWrite,
    output logic              multWrite,
    output logic              addWrite,
    output logic              s1,
    output logic              s2,
    output logic              s3,
    output logic              s4,
    output logic [31:0]       epsilon,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       result,
    output logic [ITER_W-1:0] iter_count
);

    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MULT_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_INIT  = 3'd2;
    localparam logic [2:0] S_MULT  = 3'd3;
    localparam logic [2:0] S_ADD   = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_FEED  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] mult_cnt;
    logic             last_iter;

    assign last_iter = (iter_count == ITER_LAST);

    // Next-state selection; found wins over the iteration limit in CHECK
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_INIT;
            S_INIT:  state_nxt = S_MULT;
            S_MULT:  if (mult_cnt == CNT_LAST) state_nxt = S_ADD;
            S_ADD:   state_nxt = S_CHECK;
            S_CHECK: begin
                if (found || last_iter) state_nxt = S_DONE;
                else                    state_nxt = S_FEED;
            end
            S_FEED:  state_nxt = S_MULT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Multiply hold counter, zero whenever MULT is entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                mult_cnt <= '0;
        else if (state != S_MULT) mult_cnt <= '0;
        else                     mult_cnt <= mult_cnt + CNT_W'(1);
    end

    // Run bookkeeping: epsilon, round count, result and timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epsilon    <= '0;
            iter_count <= '0;
            timeout    <= 1'b0;
            result     <= '0;
        end else if (state == S_IDLE && start) begin
            epsilon    <= eps_in;
            iter_count <= '0;
            timeout    <= 1'b0;
            result     <= '0;
        end else if (state == S_CHECK) begin
            if (iter_count != ITER_MAX)
                iter_count <= iter_count + ITER_W'(1);
            if (found)
                result <= max_in;
            else if (last_iter)
                timeout <= 1'b1;
        end
    end

    assign main_write = (state == S_LOAD);
    assign actWrite   = (state == S_INIT) || (state == S_FEED);
    assign multWrite  = (state == S_MULT);
    assign addWrite   = (state == S_ADD);
    assign s1         = (state == S_FEED);
    assign s2         = (state == S_FEED);
    assign s3         = (state == S_FEED);
    assign s4         = (state == S_FEED);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Control FSM sitting directly upstream of the MaxNet winner-take-all datapath. It sequences loading of the four input numbers and the activation/multiply/add strobes for each competition round. It feeds post-update activations back until the datapath reports a single survivor (`found`), then captures the winning value. It owns the start/done handshake, an iteration limit with timeout, and the registered epsilon and result values seen by the rest of the system.

## Interface
Parameters:
- `MULT_CYCLES`, default 1: number of consecutive cycles `multWrite` is held per round (≥1).
- `MAX_ITER`, default 64: maximum number of competition rounds before timeout (1..2^ITER_W−1).
- `ITER_W`, default 8: width of the iteration counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a new competition; sampled only in IDLE.
- `eps_in` in 32: inhibition weight; latched on accepted start.
- `found` in 1: datapath flag, exactly one positive activation (combinational from the add registers).
- `max_in` in 32: datapath winner output.
- `main_write` out 1: load the datapath input registers from num1..num4.
- `actWrite` out 1: load the activation registers.
- `multWrite` out 1: enable the PU product registers.
- `addWrite` out 1: load the activation-function output registers.
- `s1`, `s2`, `s3`, `s4` out 1 each: activation source select (0 = input x, 1 = feedback b); always equal.
- `epsilon` out 32: registered copy of `eps_in`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `timeout` out 1: sticky flag, set when the run ended without `found`.
- `result` out 32: captured winner, held until the next accepted start.
- `iter_count` out ITER_W: rounds evaluated in the current/last run.

## Operation
- States: IDLE, LOAD, INIT, MULT, ADD, CHECK, FEED, DONE.
- **IDLE**: all strobes 0.
  - On `start`=1, latch `eps_in`→`epsilon`.
  - Clear `iter_count`, `timeout` and `result`, then go to LOAD.
  - `start` outside IDLE is ignored.
- **LOAD**: `main_write`=1 → INIT.
- **INIT**: s1..s4=0, `actWrite`=1 → MULT.
- **MULT**: `multWrite`=1 for exactly `MULT_CYCLES` cycles, using an internal counter that is cleared on entry → ADD.
- **ADD**: `addWrite`=1 → CHECK.
- **CHECK**: no strobes.
  - `iter_count` increments by 1.
  - If `found`=1: `result`←`max_in`, go to DONE.
  - Else if `iter_count`+1 == `MAX_ITER`: `timeout`←1, `result` unchanged (0), go to DONE.
  - Else go to FEED.
  - `found` has priority over timeout when both apply.
- **FEED**: s1..s4=1, `actWrite`=1 → MULT.
- **DONE**: `done`=1 for one cycle → IDLE. `busy` stays 1 in DONE.
- Strobe outputs are decoded from state (Moore) and glitch-free registered-state outputs. Only the listed strobe is high in each state; s1..s4 are 0 except in FEED.
- `iter_count` saturates logically at `MAX_ITER` and never wraps.

## Timing
- Reset (`rst`=0, any time, including mid-run): immediately go to IDLE. All outputs are 0: strobes, s1..s4, `epsilon`, `busy`, `done`, `timeout`, `result`, `iter_count`. The MULT counter is cleared. Operation resumes at the first rising edge after `rst` returns to 1.
- Start accepted at edge k:
  - LOAD in cycle k+1, INIT in k+2.
  - MULT in k+3..k+2+M (M = `MULT_CYCLES`).
  - ADD in k+3+M, CHECK in k+4+M.
  - `done` high in cycle k+5+M if `found` at the first check.
- Each further round adds M+3 cycles (FEED, MULT×M, ADD, CHECK).
- Worst-case run: 4+M + (MAX_ITER−1)(M+3) + 1 cycles from start acceptance to `done`.
- `found` and `max_in` are sampled only in CHECK, one cycle after `addWrite`.
- `result`, `timeout` and `iter_count` are valid from the `done` cycle and held through IDLE until the next accepted start.
- `start` held high continuously: a new run begins in the cycle after DONE, when the FSM is back in IDLE and samples `start` again.

## Test plan
- **Reset values**: assert `rst`=0 mid-MULT → all outputs 0 in the same cycle. Release `rst`, then `start` → run restarts from LOAD.
- **Single round**: M=1; `found` forced 1 in CHECK with `max_in`=32'd77. Required:
  - Strobe order main_write, actWrite (s=0), multWrite, addWrite, one cycle each.
  - `done` pulse 6 cycles after start acceptance.
  - `result`=77, `iter_count`=1, `timeout`=0.
- **Multi-round with M=3**: `found`=1 only at the 3rd CHECK. Required:
  - Two FEED states with s1..s4=1 and `actWrite`=1.
  - `multWrite` high 3 cycles per round.
  - `iter_count`=3, `done` at k+8+2·6.
- **Timeout**: MAX_ITER=4, `found` always 0 → `timeout`=1, `result`=0, `iter_count`=4, exactly 4 CHECK states, one `done` pulse.
- **Priority**: MAX_ITER=2, `found`=1 at the 2nd CHECK → `timeout`=0, `result`=`max_in`.
- **Handshake**: pulse `start` while busy, which is ignored. Change `eps_in` mid-run: `epsilon` holds the start-time value. A back-to-back start after DONE latches the new `eps_in` and clears the prior `result`.
